filt2d_img_loader: RTL



---
 rtl/filt2d_img_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/filt2d_img_loader.sv
// filt2d_img_loader: upstream stage of the 2D filter. Takes one raster frame over a
// valid/ready stream, writes it into the shared image buffer starting at BASE, then
// pulses filt_start and waits for filt_finish before accepting the next frame.
// Optional build macro: FILT2D_LOADER_CKSUM_EN enables the frame pixel checksum on cksum.
module filt2d_img_loader #(
    parameter int WD    = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = 17,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [WD-1:0] s_data,
    input  logic          s_sof,
    output logic          cs,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [WD-1:0] din,
    output logic          filt_start,
    input  logic          filt_finish,
    output logic          busy,
    output logic          done,
    output logic          sof_err,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   cksum
);
    localparam longint NPIX = longint'(IMG_W) * longint'(IMG_H);
    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);
    localparam logic [AW-1:0] BASE_A   = AW'(BASE);

    if (longint'(BASE) + NPIX > (longint'(1) << AW)) begin : g_bad_params
        $error("filt2d_img_loader: BASE + IMG_W*IMG_H does not fit in 2^AW buffer words");
    end

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, KICK, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          take;
    logic          accept;
    logic          start_c;
    logic [IW-1:0] idx;
    logic          wr_vld_p1;
    logic [AW-1:0] addr_p1;
    logic [WD-1:0] din_p1;
    logic          done_p1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                take = 1'b1;
                // A one-pixel frame is already complete; drain it through FLUSH so
                // the start pulse never coincides with the loader's own write.
                if (s_valid && s_sof) state_nxt = (NPIX == 1) ? FLUSH : LOAD;
            end
            LOAD: begin
                take = 1'b1;
                if (s_valid && !s_sof && idx == LAST_IDX) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = KICK;
            KICK: begin
                start_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (filt_finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        accept = s_valid & take;
    end

    // Pixel index, registered buffer write, drop counter, error flag and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            wr_vld_p1 <= 1'b0;
            addr_p1   <= '0;
            din_p1    <= '0;
            drop_cnt  <= '0;
            sof_err   <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            wr_vld_p1 <= 1'b0;
            done_p1   <= (state == WAIT) && filt_finish;
            if (accept) begin
                if (state == IDLE && !s_sof) begin
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    wr_vld_p1 <= 1'b1;
                    din_p1    <= s_data;
                    if (s_sof) begin
                        addr_p1 <= BASE_A;
                        idx     <= (NPIX > 1) ? IW'(1) : '0;
                        if (state == LOAD) sof_err <= 1'b1;
                    end else begin
                        addr_p1 <= BASE_A + AW'(idx);
                        idx     <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
                    end
                end
            end
        end
    end

`ifdef FILT2D_LOADER_CKSUM_EN
    logic [15:0] sum_p1;

    // Running frame sum: restarts on every accepted SOF beat, frozen once the frame is in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        sum_p1 <= '0;
        else if (accept && s_sof)         sum_p1 <= 16'(s_data);
        else if (accept && state == LOAD) sum_p1 <= sum_p1 + 16'(s_data);
    end

    assign cksum = sum_p1;
`else
    assign cksum = '0;
`endif

    // s_ready is held low while reset is asserted so every output reads 0 in reset.
    assign s_ready    = take & ~reset;
    assign cs         = wr_vld_p1;
    assign we         = wr_vld_p1;
    assign addr       = addr_p1;
    assign din        = din_p1;
    assign filt_start = start_c;
    assign done       = done_p1;
    assign busy       = (state == LOAD) || (state == FLUSH) || wr_vld_p1;

endmodule
